// File: rtl/game_pkg.sv
// Shared constants, FSM encoding and helpers for the memory-game index generator.
package game_pkg;

    localparam int IDX_W     = 4;
    localparam int NUM_LEDS  = 16;
    localparam int NUM_SLOTS = 6;

    // Taps 16,14,13,11 of the Fibonacci LFSR.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Lowest index whose mask bit is clear; the downward scan leaves the lowest winner.
    function automatic logic [IDX_W-1:0] lowest_clear(input logic [NUM_LEDS-1:0] mask);
        lowest_clear = '0;
        for (int i = NUM_LEDS - 1; i >= 0; i--) begin
            if (!mask[i]) lowest_clear = IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; shifts left, feedback enters at bit 0.
module lfsr16
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= SEED;
        else      q <= {q[14:0], ^(q & LFSR_TAPS)};
    end

endmodule

// File: rtl/pair_index_generator.sv
// Draws six distinct LED indices per round from a free-running LFSR, with a
// priority-encoder fallback once too many candidates have been rejected.
module pair_index_generator
    import game_pkg::*;
#(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          MAX_TRIES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic [IDX_W-1:0] A,
    output logic [IDX_W-1:0] B,
    output logic [IDX_W-1:0] C,
    output logic [IDX_W-1:0] D,
    output logic [IDX_W-1:0] E,
    output logic [IDX_W-1:0] F,
    output logic             endPairs,
    output state_t           state,
    output logic [15:0]      lfsr
);

    localparam int                 TRIES_W   = (MAX_TRIES < 1) ? 1 : $clog2(MAX_TRIES + 1);
    localparam logic [TRIES_W-1:0] TRIES_MAX = TRIES_W'(MAX_TRIES);

    state_t              state_next;
    logic [NUM_LEDS-1:0] mask;
    logic [2:0]          slot;
    logic [TRIES_W-1:0]  tries;
    logic                enable_q;
    logic                start, fallback, wr_en, reject, last;
    logic [IDX_W-1:0]    cand, wr_idx;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr)
    );

    // Inside GEN only a fresh rising enable restarts, so a held level cannot
    // abort every round; in IDLE and DONE the level itself starts a round.
    always_comb begin
        start    = (state == GEN) ? (enable && !enable_q) : enable;
        cand     = lfsr[IDX_W-1:0];
        fallback = (tries == TRIES_MAX);
        wr_idx   = fallback ? lowest_clear(mask) : cand;
        wr_en    = (state == GEN) && !start && (fallback || !mask[cand]);
        reject   = (state == GEN) && !start && !fallback && mask[cand];
        last     = wr_en && (slot == 3'(NUM_SLOTS - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = GEN;
            GEN:     if (last) state_next = DONE;
            DONE:    state_next = start ? GEN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable_q <= 1'b0;
            endPairs <= 1'b0;
            mask     <= '0;
            slot     <= '0;
            tries    <= '0;
            A        <= '0;
            B        <= '0;
            C        <= '0;
            D        <= '0;
            E        <= '0;
            F        <= '0;
        end else begin
            enable_q <= enable;
            endPairs <= last;
            if (start) begin
                mask  <= '0;
                slot  <= '0;
                tries <= '0;
            end else if (wr_en) begin
                mask[wr_idx] <= 1'b1;
                slot         <= slot + 3'd1;
                case (slot)
                    3'd0:    A <= wr_idx;
                    3'd1:    B <= wr_idx;
                    3'd2:    C <= wr_idx;
                    3'd3:    D <= wr_idx;
                    3'd4:    E <= wr_idx;
                    3'd5:    F <= wr_idx;
                    default: ;
                endcase
            end else if (reject) begin
                // reject implies tries < TRIES_MAX, so this saturates by construction.
                tries <= tries + TRIES_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pair_index_generator.sv
// Bench for pair_index_generator: a spec-level round predictor driven by a bench-side LFSR.
module tb_pair_index_generator;
    import game_pkg::*;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_a = 1'b0;
    logic        en_b = 1'b0;
    logic [3:0]  a_A, a_B, a_C, a_D, a_E, a_F;
    logic [3:0]  b_A, b_B, b_C, b_D, b_E, b_F;
    logic        a_end, b_end;
    state_t      a_st, b_st;
    logic [15:0] a_lfsr, b_lfsr;
    logic [23:0] a_set, b_set;
    logic [15:0] m_lfsr;
    int          n_checks = 0;
    int          n_pass = 0;

    assign a_set = {a_A, a_B, a_C, a_D, a_E, a_F};
    assign b_set = {b_A, b_B, b_C, b_D, b_E, b_F};

    always #5 clk = ~clk;

    pair_index_generator #(.SEED(SEED), .MAX_TRIES(32)) dut_a (
        .clk(clk), .rst(rst), .enable(en_a),
        .A(a_A), .B(a_B), .C(a_C), .D(a_D), .E(a_E), .F(a_F),
        .endPairs(a_end), .state(a_st), .lfsr(a_lfsr)
    );

    pair_index_generator #(.SEED(SEED), .MAX_TRIES(0)) dut_b (
        .clk(clk), .rst(rst), .enable(en_b),
        .A(b_A), .B(b_B), .C(b_C), .D(b_D), .E(b_E), .F(b_F),
        .endPairs(b_end), .state(b_st), .lfsr(b_lfsr)
    );

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    // Model of the LFSR value present during the current cycle.
    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= SEED;
        else      m_lfsr <= lfsr_next(m_lfsr);
    end

    // Predicts a whole round from the LFSR value seen before the start edge:
    // result set {A..F} and the edge number after which endPairs is high.
    function automatic void predict(input logic [15:0] l0, input int max_tries,
                                    output logic [23:0] e, output int n);
        bit          used [16];
        int          tries, slot, pick;
        logic [15:0] l;
        l = l0; tries = 0; slot = 0; n = 0; e = '0;
        foreach (used[j]) used[j] = 1'b0;
        while (slot < 6) begin
            n++;
            l = lfsr_next(l);
            pick = int'(l[3:0]);
            if (tries >= max_tries) begin
                pick = -1;
                for (int j = 15; j >= 0; j--) if (!used[j]) pick = j;
            end else if (used[pick]) begin
                tries++;
                pick = -1;
            end
            if (pick >= 0) begin
                used[pick] = 1'b1;
                e[23 - 4*slot -: 4] = 4'(pick);
                slot++;
            end
        end
    endfunction

    function automatic bit all_distinct(input logic [23:0] s);
        all_distinct = 1'b1;
        for (int i = 0; i < 6; i++)
            for (int j = i + 1; j < 6; j++)
                if (s[23 - 4*i -: 4] == s[23 - 4*j -: 4]) all_distinct = 1'b0;
    endfunction

    // Called just after a start edge; returns the edge index of the first endPairs
    // seen at a negedge (-1 on timeout) and the set visible then.
    task automatic wait_done(input bit use_b, input int budget, output int k, output logic [23:0] got);
        k = -1;
        got = '0;
        for (int i = 0; i <= budget; i++) begin
            @(negedge clk);
            if ((use_b ? b_end : a_end) === 1'b1) begin
                k = i;
                got = use_b ? b_set : a_set;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        n_checks++; if (a_set !== 24'h0) $display("FAIL reset_a_outputs: got %h expected %h", a_set, 24'h0); else n_pass++;
        n_checks++; if (a_end !== 1'b0) $display("FAIL reset_a_end: got %b expected 0", a_end); else n_pass++;
        n_checks++; if (a_st !== IDLE) $display("FAIL reset_a_state: got %0d expected %0d", a_st, IDLE); else n_pass++;
        n_checks++; if (b_set !== 24'h0) $display("FAIL reset_b_outputs: got %h expected %h", b_set, 24'h0); else n_pass++;
        n_checks++; if (b_end !== 1'b0) $display("FAIL reset_b_end: got %b expected 0", b_end); else n_pass++;
        n_checks++; if (b_st !== IDLE) $display("FAIL reset_b_state: got %0d expected %0d", b_st, IDLE); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [23:0] exp, got;
        logic [15:0] l0;
        int          n, k;
        @(negedge clk);
        en_a = 1'b1; l0 = m_lfsr;
        @(posedge clk); #1 en_a = 1'b0;
        predict(l0, 32, exp, n);
        wait_done(1'b0, 40, k, got);
        n_checks++; if (k != n) $display("FAIL basic_latency: got %0d expected %0d", k, n); else n_pass++;
        n_checks++; if (!(k >= 6 && k <= 38)) $display("FAIL basic_latency_bound: got %0d expected 6..38", k); else n_pass++;
        n_checks++; if (got !== exp) $display("FAIL basic_set: got %h expected %h", got, exp); else n_pass++;
        n_checks++; if (!all_distinct(got)) $display("FAIL basic_distinct: got %h expected distinct", got); else n_pass++;
        if (k < 0) return;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_checks++;
            if (a_end !== 1'b0 || a_set !== exp)
                $display("FAIL basic_hold: got end=%b set=%h expected end=0 set=%h", a_end, a_set, exp);
            else n_pass++;
        end
    endtask

    task automatic test_max_tries_zero();
        logic [23:0] got;
        int          k;
        @(negedge clk);
        en_b = 1'b1;
        @(posedge clk); #1 en_b = 1'b0;
        wait_done(1'b1, 40, k, got);
        n_checks++; if (k != 6) $display("FAIL zero_latency: got %0d expected 6", k); else n_pass++;
        n_checks++; if (got !== 24'h012345) $display("FAIL zero_set: got %h expected 012345", got); else n_pass++;
        @(negedge clk);
        n_checks++; if (b_end !== 1'b0) $display("FAIL zero_pulse_width: got %b expected 0", b_end); else n_pass++;
    endtask

    task automatic test_restart();
        logic [23:0] exp, got;
        logic [15:0] l0;
        int          n, k;
        @(negedge clk);
        en_a = 1'b1;
        @(posedge clk); #1 en_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (a_end !== 1'b0) $display("FAIL restart_early_end: got %b expected 0", a_end); else n_pass++;
            @(posedge clk);
        end
        @(negedge clk);
        en_a = 1'b1; l0 = m_lfsr;
        @(posedge clk); #1 en_a = 1'b0;
        predict(l0, 32, exp, n);
        wait_done(1'b0, 40, k, got);
        n_checks++; if (k != n) $display("FAIL restart_latency: got %0d expected %0d", k, n); else n_pass++;
        n_checks++; if (k < 6) $display("FAIL restart_min_latency: got %0d expected >=6", k); else n_pass++;
        n_checks++; if (got !== exp) $display("FAIL restart_set: got %h expected %h", got, exp); else n_pass++;
    endtask

    task automatic test_hold();
        logic [23:0] exp, got;
        logic [15:0] l0;
        int          n, k, cyc;
        cyc = 0;
        @(negedge clk);
        en_a = 1'b1; l0 = m_lfsr;
        while (cyc < 1000) begin
            @(posedge clk);
            predict(l0, 32, exp, n);
            wait_done(1'b0, 40, k, got);
            n_checks++; if (k != n) $display("FAIL hold_latency: got %0d expected %0d", k, n); else n_pass++;
            n_checks++; if (got !== exp) $display("FAIL hold_set: got %h expected %h", got, exp); else n_pass++;
            n_checks++; if (!all_distinct(got)) $display("FAIL hold_distinct: got %h expected distinct", got); else n_pass++;
            if (k < 0) break;
            cyc += k + 1;
            l0 = m_lfsr;
        end
        en_a = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        logic [23:0] exp, got;
        logic [15:0] l0;
        int          n, k;
        @(negedge clk);
        en_a = 1'b1;
        @(posedge clk); #1 en_a = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        n_checks++; if (a_set !== 24'h0) $display("FAIL midreset_outputs: got %h expected %h", a_set, 24'h0); else n_pass++;
        n_checks++; if (a_end !== 1'b0) $display("FAIL midreset_end: got %b expected 0", a_end); else n_pass++;
        n_checks++; if (a_st !== IDLE) $display("FAIL midreset_state: got %0d expected %0d", a_st, IDLE); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        en_a = 1'b1; l0 = m_lfsr;
        @(posedge clk); #1 en_a = 1'b0;
        predict(l0, 32, exp, n);
        wait_done(1'b0, 40, k, got);
        n_checks++; if (k != n) $display("FAIL midreset_latency: got %0d expected %0d", k, n); else n_pass++;
        n_checks++; if (got !== exp) $display("FAIL midreset_set: got %h expected %h", got, exp); else n_pass++;
    endtask

    task automatic test_random();
        logic [23:0] exp, got;
        logic [15:0] l0;
        int          n, k, gap, missing;
        bit          seen [6][16];
        foreach (seen[s, v]) seen[s][v] = 1'b0;
        @(negedge clk);
        for (int r = 0; r < 4000; r++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            en_a = 1'b1; l0 = m_lfsr;
            @(posedge clk); #1 en_a = 1'b0;
            predict(l0, 32, exp, n);
            wait_done(1'b0, 40, k, got);
            n_checks++; if (k != n) $display("FAIL random_latency: got %0d expected %0d", k, n); else n_pass++;
            n_checks++; if (got !== exp) $display("FAIL random_set: got %h expected %h", got, exp); else n_pass++;
            n_checks++; if (!all_distinct(got)) $display("FAIL random_distinct: got %h expected distinct", got); else n_pass++;
            if (k < 0) break;
            for (int s = 0; s < 6; s++) seen[s][got[23 - 4*s -: 4]] = 1'b1;
        end
        for (int s = 0; s < 6; s++) begin
            missing = 0;
            for (int v = 0; v < 16; v++) if (!seen[s][v]) missing++;
            n_checks++; if (missing != 0) $display("FAIL random_coverage_slot%0d: got %0d missing expected 0", s, missing); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_tries_zero();
        test_restart();
        test_hold();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
